core_internal_memory_multiplexer: RTL and testbench



---
 rtl/core_internal_memory_multiplexer.sv | 137 +++++++++++++
 tb/tb_core_internal_memory_multiplexer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_internal_memory_multiplexer.sv
// core_internal_memory_multiplexer
// Shares one downstream memory bus between the I-cache miss port (I) and the
// vector memory controller (V). One transaction is outstanding at a time:
// IDLE grants a port, ISSUE drives the downstream request, WAIT_RESP routes
// the single response back to the owner as a one-cycle pulse.
// Optional macro: MUX_ROUND_ROBIN_EN -- round-robin tie break instead of
// fixed priority to port I.
module core_internal_memory_multiplexer #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  // port I
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_rdata,
  // port V
  input  logic              v_req_valid,
  output logic              v_req_ready,
  input  logic              v_req_write,
  input  logic [ADDR_W-1:0] v_req_addr,
  input  logic [DATA_W-1:0] v_req_wdata,
  output logic              v_resp_valid,
  output logic [DATA_W-1:0] v_resp_rdata,
  // downstream
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t state;
  logic   owner;      // 0 = port I, 1 = port V
  logic   prefer_i;
  logic   grant_i;
  logic   grant_v;

`ifdef MUX_ROUND_ROBIN_EN
  logic   last_v;     // 1 when V was granted last; reset value favours I

  // Round-robin pointer: remember which port was granted most recently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_v <= 1'b1;
    end else if (grant_i || grant_v) begin
      last_v <= grant_v;
    end
  end

  // Tie break favours the port not granted last
  always_comb begin
    prefer_i = last_v;
  end
`else
  // Fixed priority: port I always wins a tie
  always_comb begin
    prefer_i = 1'b1;
  end
`endif

  // Grant decision, only offered while idle
  always_comb begin
    grant_i = 1'b0;
    grant_v = 1'b0;
    if (state == IDLE) begin
      if (i_req_valid && (!v_req_valid || prefer_i)) begin
        grant_i = 1'b1;
      end else if (v_req_valid) begin
        grant_v = 1'b1;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign v_req_ready = grant_v;

  // Transaction FSM with registered downstream request and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      i_resp_valid  <= 1'b0;
      v_resp_valid  <= 1'b0;
      i_resp_rdata  <= '0;
      v_resp_rdata  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      v_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_v) begin
            owner         <= grant_v;
            mem_req_valid <= 1'b1;
            mem_req_write <= grant_v ? v_req_write : i_req_write;
            mem_req_addr  <= grant_v ? v_req_addr  : i_req_addr;
            mem_req_wdata <= grant_v ? v_req_wdata : i_req_wdata;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            if (owner) begin
              v_resp_rdata <= mem_resp_rdata;
              v_resp_valid <= 1'b1;
            end else begin
              i_resp_rdata <= mem_resp_rdata;
              i_resp_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_internal_memory_multiplexer.sv
// Randomized scoreboard bench for core_internal_memory_multiplexer.
// A transaction-level model predicts grants, downstream requests and routed
// responses; a DRAM model with a memory array supplies response data.
module tb_core_internal_memory_multiplexer;
  localparam int AW = 21;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req_valid, i_req_ready, i_req_write, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata, i_resp_rdata;
  logic          v_req_valid, v_req_ready, v_req_write, v_resp_valid;
  logic [AW-1:0] v_req_addr;
  logic [DW-1:0] v_req_wdata, v_resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_rdata;

  always #5 clk = ~clk;

  core_internal_memory_multiplexer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_req_write(v_req_write),
    .v_req_addr(v_req_addr), .v_req_wdata(v_req_wdata),
    .v_resp_valid(v_resp_valid), .v_resp_rdata(v_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct packed {
    logic          port;   // 0 = I, 1 = V
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  req_t          req_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int checks = 0;
  int fails  = 0;

  // model state
  bit busy;        // an upstream request is accepted and not yet answered
  bit issue_pend;  // accepted request waiting for downstream acceptance
  bit mem_out;     // downstream accepted, DRAM response not yet returned
  int cnt;
  logic [DW-1:0] resp_data;
  bit last_v;
  bit i_taken, v_taken;
  int p_i, p_v, p_ready, p_spur;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    case ($urandom_range(3))
      0: a = 21'h00100;
      1: a = 21'h1FFFF8;
      2: a = AW'($urandom_range(0, 31) * 8);
      default: a = AW'($urandom);
    endcase
    return a;
  endfunction

  function automatic bit prefer_i();
`ifdef MUX_ROUND_ROBIN_EN
    return last_v;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_i_ready"}, DW'(i_req_ready), '0);
    chk({tag, "_v_ready"}, DW'(v_req_ready), '0);
    chk({tag, "_mem_valid"}, DW'(mem_req_valid), '0);
    chk({tag, "_mem_write"}, DW'(mem_req_write), '0);
    chk({tag, "_mem_addr"}, DW'(mem_req_addr), '0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, '0);
    chk({tag, "_i_resp_valid"}, DW'(i_resp_valid), '0);
    chk({tag, "_v_resp_valid"}, DW'(v_resp_valid), '0);
    chk({tag, "_i_rdata"}, i_resp_rdata, '0);
    chk({tag, "_v_rdata"}, v_resp_rdata, '0);
  endtask

  // One clock of stimulus, DRAM model and grant/issue prediction
  task automatic step();
    bit exp_i, exp_v;
    req_t r;
    logic [DW-1:0] d;
    @(negedge clk);
    if (i_resp_valid || v_resp_valid) busy = 1'b0;
    chk("mem_req_valid", DW'(mem_req_valid), DW'(issue_pend));
    if (issue_pend && req_q.size() > 0) begin
      chk("mem_req_write", DW'(mem_req_write), DW'(req_q[0].write));
      chk("mem_req_addr", DW'(mem_req_addr), DW'(req_q[0].addr));
      chk("mem_req_wdata", mem_req_wdata, req_q[0].wdata);
    end
    // DRAM response or spurious pulse while no transaction is in WAIT_RESP
    mem_resp_valid = 1'b0;
    mem_resp_rdata = {$urandom, $urandom};
    if (mem_out) begin
      cnt--;
      if (cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_data;
        mem_out = 1'b0;
      end
    end else if ($urandom_range(99) < p_spur) begin
      mem_resp_valid = 1'b1;
    end
    // upstream requests: hold until accepted, then maybe present a new one
    if (i_taken || !i_req_valid) begin
      i_req_valid = ($urandom_range(99) < p_i);
      i_req_write = $urandom_range(1);
      i_req_addr  = pick_addr();
      i_req_wdata = {$urandom, $urandom};
      i_taken = 1'b0;
    end
    if (v_taken || !v_req_valid) begin
      v_req_valid = ($urandom_range(99) < p_v);
      v_req_write = $urandom_range(1);
      v_req_addr  = pick_addr();
      v_req_wdata = {$urandom, $urandom};
      v_taken = 1'b0;
    end
    mem_req_ready = ($urandom_range(99) < p_ready);
    #1;
    // downstream handshake happens at the coming edge
    if (issue_pend && mem_req_ready && req_q.size() > 0) begin
      r = req_q.pop_front();
      if (r.write) begin
        mem[r.addr] = r.wdata;
        d = {$urandom, $urandom};
      end else begin
        d = mem.exists(r.addr) ? mem[r.addr] : ({{(DW-AW){1'b0}}, r.addr} ^ 64'hA5A5_5A5A_0F0F_F0F0);
      end
      rsp_q.push_back('{port: r.port, data: d});
      resp_data  = d;
      cnt        = $urandom_range(1, 3);
      mem_out    = 1'b1;
      issue_pend = 1'b0;
    end
    exp_i = !busy && i_req_valid && (!v_req_valid || prefer_i());
    exp_v = !busy && v_req_valid && !exp_i;
    chk("i_req_ready", DW'(i_req_ready), DW'(exp_i));
    chk("v_req_ready", DW'(v_req_ready), DW'(exp_v));
    if (exp_i) begin
      req_q.push_back('{port: 1'b0, write: i_req_write, addr: i_req_addr, wdata: i_req_wdata});
      i_taken = 1'b1;
      last_v  = 1'b0;
    end else if (exp_v) begin
      req_q.push_back('{port: 1'b1, write: v_req_write, addr: v_req_addr, wdata: v_req_wdata});
      v_taken = 1'b1;
      last_v  = 1'b1;
    end
    if (exp_i || exp_v) begin
      busy       = 1'b1;
      issue_pend = 1'b1;
    end
  endtask

  task automatic run(input int n, input int pi, input int pv, input int pr, input int ps);
    p_i = pi; p_v = pv; p_ready = pr; p_spur = ps;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_model();
    req_q.delete();
    rsp_q.delete();
    busy = 1'b0; issue_pend = 1'b0; mem_out = 1'b0; cnt = 0;
    last_v = 1'b1; i_taken = 1'b1; v_taken = 1'b1;
  endtask

  // Reset while the mux waits for the DRAM; the late response must vanish
  task automatic reset_mid();
    int n = 0;
    p_i = 50; p_v = 50; p_ready = 60; p_spur = 0;
    while (!mem_out && n < 200) begin
      step();
      n++;
    end
    chk("reach_wait_resp", DW'(mem_out), DW'(1));
    @(negedge clk);
    reset_n = 1'b0;
    i_req_valid = 1'b0; v_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 check_zero("after_drop");
    clear_model();
    reset_n = 1'b1;
  endtask

  // Response monitor: every pulse must match the oldest expected response
  always @(negedge clk) begin
    rsp_t e;
    if (reset_n) begin
      if (i_resp_valid && v_resp_valid) chk("both_resp_valid", DW'(1), DW'(0));
      else if (i_resp_valid || v_resp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_resp", DW'(1), DW'(0));
        end else begin
          e = rsp_q.pop_front();
          chk("resp_port", DW'(v_resp_valid), DW'(e.port));
          chk("resp_rdata", v_resp_valid ? v_resp_rdata : i_resp_rdata, e.data);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    v_req_valid = 1'b0; v_req_write = 1'b0; v_req_addr = '0; v_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    mem[21'h00100] = 64'hDEAD_BEEF_CAFE_F00D;
    clear_model();
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run(400, 30, 30, 70, 0);    // mixed light traffic
    run(300, 100, 100, 80, 0);  // both ports held valid: tie break rule
    run(150, 0, 100, 80, 0);    // I quiet: V served
    run(400, 40, 40, 20, 30);   // slow downstream, spurious responses
    reset_mid();
    run(200, 60, 60, 50, 20);
    reset_mid();
    run(300, 100, 30, 100, 10); // back-to-back issue in the response cycle
    run(60, 0, 0, 100, 0);      // drain
    chk("drain_resp_queue", DW'(rsp_q.size()), '0);
    chk("drain_req_queue", DW'(req_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
